fetch_exec_controller: RTL
==========================

FETCH_EXEC_CONTROLLER -- requirements
Module: fetch_exec_controller

Interface
REQ-001 Parameter PC_WIDTH, 11, width of the program-counter address.
REQ-002 Parameter IR_WIDTH, 14, width of the instruction word.
REQ-003 Port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port stall  input  1  when 1, the FSM holds its state and no load strobe is asserted.
REQ-006 Port ir_in  input  IR_WIDTH  current instruction register contents, valid from T4 onward.
REQ-007 Port load_mar  output  1  MAR captures PC on the next edge.
REQ-008 Port load_pc  output  1  PC updates on the next edge.
REQ-009 Port pc_sel  output  1  PC source select: 0 = PC+1, 1 = ir_in[10:0] (branch target).
REQ-010 Port load_ir  output  1  IR captures ROM data on the next edge.
REQ-011 Port load_w  output  1  W register captures the ALU result on the next edge.
REQ-012 Port alu_op  output  3  ALU function: 0 pass k, 1 k+W, 2 k-W, 3 k&W, 4 k|W, 5 k^W; 0 when load_w=0.
REQ-013 Port state  output  3  current FSM state code.
REQ-014 Port halted  output  1  1 while the FSM is in HALT.
REQ-015 Port instr_count  output  16  count of retired instructions.

Function
REQ-016 The FSM SHALL have states T0_INIT=0, T1=1, T2=2, T3=3, T4=4 and HALT=5.
REQ-017 The block SHALL follow the transitions T0_INIT->T1->T2->T3->T4->T1; HALT SHALL be left only by reset.
REQ-018 The block SHALL decode all strobes combinationally from the current state, and from ir_in in T4 (Moore decode plus T4 decode); every strobe SHALL be 0 when reset=1 or stall=1.
REQ-019 In T1, load_mar SHALL be 1.
REQ-020 In T2, load_pc SHALL be 1 with pc_sel=0.
REQ-021 In T3, load_ir SHALL be 1.
REQ-022 In T4, decode SHALL use ir_in[13:8]:
  - 1100xx MOVLW: alu_op 0
  - 11111x ADDLW: alu_op 1
  - 11110x SUBLW: alu_op 2
  - 111001 ANDLW: alu_op 3
  - 111000 IORLW: alu_op 4
  - 111010 XORLW: alu_op 5
  In each of these cases load_w SHALL be 1.
REQ-023 In T4, ir_in[13:11]=101 (GOTO) SHALL assert load_pc=1 with pc_sel=1 and load_w=0.
REQ-024 In T4, ir_in == 14'h0000 (NOP) SHALL assert no strobe.
REQ-025 Any other T4 encoding SHALL be illegal: no strobe is asserted, the next state is HALT, and instr_count does not increment.
REQ-026 Each legal T4 that is not stalled SHALL increment instr_count by 1 on the exiting edge; instr_count wraps 16'hFFFF->0.
REQ-027 A stall asserted in any state SHALL freeze the state and instr_count, and deassert all strobes; on release, the block resumes in the same state.
REQ-028 Every fetch+execute SHALL take exactly 4 cycles (T1..T4); the first instruction retires on the 5th edge after reset release.
REQ-029 In HALT, all strobes SHALL be 0, halted SHALL be 1, and stall SHALL be ignored.
REQ-030 No output SHALL be X for any ir_in value, including X-free illegal codes.

Reset
REQ-031 While reset=1 on an edge, the block SHALL set state to T0_INIT, set instr_count to 0 and set halted to 0.
REQ-032 While reset=1, all strobes SHALL be 0 and alu_op SHALL be 0.
REQ-033 Reset asserted mid-cycle, in any state including HALT, SHALL abandon the instruction without incrementing instr_count.

Verification
REQ-034 Reset release with ir_in=14'h3044: state sequence 0,1,2,3,4,1; in T4, load_w=1 and alu_op=0; instr_count=1 after the T4 edge.
REQ-035 ir_in=14'h3E05 in T4 -> load_w=1, alu_op=1; ir_in=14'h3C05 -> alu_op=2; ir_in=14'h3A05 -> alu_op=5.
REQ-036 ir_in=14'h2807 in T4 -> load_pc=1, pc_sel=1, load_w=0; next state T1.
REQ-037 ir_in=14'h0100 in T4 -> next state HALT, halted=1, all strobes 0 for 10 cycles, instr_count unchanged; reset returns state to 0.
REQ-038 stall=1 for 3 cycles during T2 -> state stays 2 with load_pc=0; after release, load_pc=1 for one cycle, then state T3.
REQ-039 instr_count preloaded to 16'hFFFF through 65535 ADDLW retirements, plus one more -> instr_count=0.

Source files
------------

// File: rtl/fetch_exec_controller.sv
// Four-phase fetch/execute sequencer: T1 loads MAR, T2 bumps PC, T3 loads IR,
// T4 decodes the instruction into W-register / branch strobes.
module fetch_exec_controller #(
   parameter int PC_WIDTH = 11,
   parameter int IR_WIDTH = 14
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic [IR_WIDTH-1:0] ir_in,
   output logic                load_mar,
   output logic                load_pc,
   output logic                pc_sel,
   output logic                load_ir,
   output logic                load_w,
   output logic [2:0]          alu_op,
   output logic [2:0]          state,
   output logic                halted,
   output logic [15:0]         instr_count
);

   typedef enum logic [2:0] {
      T0_INIT = 3'd0,
      T1      = 3'd1,
      T2      = 3'd2,
      T3      = 3'd3,
      T4      = 3'd4,
      HALT    = 3'd5
   } state_e;

   // The GOTO target is taken from the low bits below the 3-bit opcode field.
   if (PC_WIDTH > IR_WIDTH - 3) begin : g_pc_width_check
      $error("PC_WIDTH does not fit below the GOTO opcode field");
   end

   state_e      state_q, state_d;
   logic [15:0] instr_count_q, instr_count_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= T0_INIT;
         instr_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         instr_count_q <= instr_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      instr_count_d = instr_count_q;
      load_mar      = 1'b0;
      load_pc       = 1'b0;
      pc_sel        = 1'b0;
      load_ir       = 1'b0;
      load_w        = 1'b0;
      alu_op        = 3'd0;
      // Reset and stall both suppress every strobe and freeze the sequencer.
      if (!reset && !stall) begin
         case (state_q)
            T0_INIT: state_d = T1;
            T1: begin
               load_mar = 1'b1;
               state_d  = T2;
            end
            T2: begin
               load_pc = 1'b1;
               state_d = T3;
            end
            T3: begin
               load_ir = 1'b1;
               state_d = T4;
            end
            T4: begin
               state_d       = T1;
               instr_count_d = instr_count_q + 16'd1;
               casez (ir_in[13:8])
                  6'b1100??: begin load_w = 1'b1; alu_op = 3'd0; end
                  6'b11111?: begin load_w = 1'b1; alu_op = 3'd1; end
                  6'b11110?: begin load_w = 1'b1; alu_op = 3'd2; end
                  6'b111001: begin load_w = 1'b1; alu_op = 3'd3; end
                  6'b111000: begin load_w = 1'b1; alu_op = 3'd4; end
                  6'b111010: begin load_w = 1'b1; alu_op = 3'd5; end
                  6'b101???: begin load_pc = 1'b1; pc_sel = 1'b1; end
                  default: begin
                     // Only the all-zero word is a NOP; anything else here is illegal.
                     if (ir_in != '0) begin
                        state_d       = HALT;
                        instr_count_d = instr_count_q;
                     end
                  end
               endcase
            end
            default: state_d = HALT;
         endcase
      end
   end

   assign state       = state_q;
   assign halted      = (state_q == HALT);
   assign instr_count = instr_count_q;

endmodule
